inst_loader: RTL
================

Name: inst_loader

Overview:
- Hardware boot/program loader that fills instruction memory from a byte stream, e.g. from a UART receiver.
- Frees the SoC from backdoor memory preloading.
- Sits between the byte-stream source and the instruction memory write port.
- Holds the core in reset while loading and releases it only after a checksum-verified frame.

Parameters:
ADDR_WIDTH, 12, instruction memory word-address width; max words per frame = 2**ADDR_WIDTH
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 100000, max clk cycles allowed between accepted bytes inside a frame

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset; one clock; reset is synchronous and active-low
rx_data_i  input  8  incoming byte
rx_valid_i  input  1  rx_data_i valid
rx_ready_o  output  1  loader can accept a byte
mem_we_o  output  1  instruction memory write strobe, one-cycle pulse
mem_addr_o  output  ADDR_WIDTH  word address of the write
mem_wdata_o  output  32  instruction word to write
core_rst_n_o  output  1  active-low reset to the core
load_done_o  output  1  last frame loaded, checksum good
load_err_o  output  1  last frame failed
busy_o  output  1  frame in progress (state CNT_LO..CSUM)

Behaviour:
- Reset (rst_n=0 at a clock edge): every output is 0, except that core_rst_n_o is also 0 (core held in reset). State=IDLE; counters, checksum and byte index cleared.
- rx_ready_o is registered: 0 during reset, 1 from the first cycle after rst_n=1, and stays 1 in all states.
- A byte is accepted on a rising edge with rx_valid_i=1 and rx_ready_o=1. Exactly one byte per accepting edge; no stalls.
- Frame format: SYNC_BYTE, CNT_LO, CNT_HI, 4*N payload bytes, CSUM.
  - N = {CNT_HI,CNT_LO}, the word count.
  - Each word is little-endian: first byte goes to bits [7:0].
  - CSUM = XOR of all payload bytes only (0x00 when N=0).
- States:
  - IDLE: non-SYNC bytes are discarded. SYNC -> CNT_LO.
  - CNT_LO: store the byte -> CNT_HI.
  - CNT_HI: store the byte, then:
    - N > 2**ADDR_WIDTH -> ERR.
    - N = 0 -> CSUM.
    - otherwise -> DATA.
  - DATA:
    - Accumulate bytes; XOR each into the running checksum.
    - On the 4th byte of a word: the next cycle has mem_we_o=1 for one cycle, mem_addr_o = word index (0 for the first word of each frame), mem_wdata_o = {b3,b2,b1,b0}.
    - After word N-1 -> CSUM.
  - CSUM: match -> DONE; mismatch -> ERR. Words already written are not rolled back.
  - DONE: load_done_o=1 and core_rst_n_o=1, both registered and visible the cycle after the CSUM byte. SYNC -> CNT_LO, with core_rst_n_o=0 and load_done_o=0 the next cycle. Other bytes are ignored.
  - ERR: load_err_o=1 (sticky) and core_rst_n_o=0. SYNC -> CNT_LO, with load_err_o cleared the next cycle. Other bytes are ignored.
- core_rst_n_o=0 in every state except DONE.
- Entering CNT_LO from any state clears the word index, byte index and checksum.
- mem_we_o, mem_addr_o and mem_wdata_o are registered. mem_addr_o and mem_wdata_o hold their last values when mem_we_o=0.
- Timeout:
  - A counter runs in CNT_LO..CSUM and clears on every accepted byte.
  - On reaching TIMEOUT cycles without an accepted byte -> ERR.
  - Idle gaps in IDLE, DONE and ERR never time out.
- Simultaneous events: an accepted byte on the same edge the timeout would fire takes priority, and no timeout occurs.
- rst_n=0 mid-frame: immediate return to IDLE with reset outputs. No further writes occur for the aborted frame, and the next frame starts at address 0.
- The counter and word index are wide enough for N = 2**ADDR_WIDTH exactly; no wrap-around.

Test Plan:
- Frame A5 02 00 13 00 00 00 93 00 10 00 90 -> mem_we pulses at addr 0 with 0x00000013 and addr 1 with 0x00100093, one cycle after the 4th byte of each word; load_done_o=1 and core_rst_n_o=1 one cycle after byte 0x90.
- Same frame with CSUM 0x91 -> both writes still occur; load_err_o=1; core_rst_n_o stays 0; load_done_o=0.
- A5 00 00 00 -> no mem_we_o pulse; load_done_o=1; core_rst_n_o=1. Then A5 again -> core_rst_n_o=0 and load_done_o=0 the next cycle.
- ADDR_WIDTH=12, A5 01 10 (N=0x1001) -> ERR right after CNT_HI with no writes. A5 00 10 (N=4096) is accepted, and the last write goes to addr 0xFFF.
- TIMEOUT=16, send A5 02 then no valid for 16 cycles -> load_err_o=1 on cycle 16. A byte accepted on cycle 16 instead -> no error. A following full valid frame -> DONE.
- Bytes 00 FF 13 in IDLE -> ignored, no state change. rst_n=0 for one cycle after 6 payload bytes -> all outputs 0 with no further writes. The next frame writes its first word to addr 0.

Source files
------------

// File: rtl/inst_loader.sv
// Boot loader: parses SYNC/count/payload/checksum frames from a byte stream,
// writes 32-bit words to instruction memory and gates the core reset.
module inst_loader #(
    parameter int         ADDR_WIDTH = 12,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  core_rst_n_o,
    output logic                  load_done_o,
    output logic                  load_err_o,
    output logic                  busy_o
);

    localparam int          TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} state_t;

    state_t              state;
    logic [7:0]          cnt_lo;
    logic [15:0]         word_cnt;
    logic [ADDR_WIDTH:0] word_idx;   // one extra bit so a full 2**ADDR_WIDTH frame never wraps
    logic [1:0]          byte_idx;
    logic [23:0]         word_buf;
    logic [7:0]          csum;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                accept;
    logic [15:0]         n_in;
    logic                last_word;

    assign accept    = rx_valid_i && rx_ready_o;
    assign n_in      = {rx_data_i, cnt_lo};
    assign last_word = (32'(word_idx) + 32'd1) == 32'(word_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rx_ready_o   <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            core_rst_n_o <= 1'b0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
            busy_o       <= 1'b0;
            cnt_lo       <= '0;
            word_cnt     <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            csum         <= '0;
            tmo_cnt      <= '0;
        end else begin
            rx_ready_o <= 1'b1;
            mem_we_o   <= 1'b0;

            if (accept)
                tmo_cnt <= '0;
            else if (busy_o)
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                IDLE, DONE, ERR: begin
                    if (accept && rx_data_i == SYNC_BYTE) begin
                        state        <= CNT_LO;
                        busy_o       <= 1'b1;
                        load_done_o  <= 1'b0;
                        load_err_o   <= 1'b0;
                        core_rst_n_o <= 1'b0;
                        word_idx     <= '0;
                        byte_idx     <= '0;
                        csum         <= '0;
                    end
                end
                CNT_LO: begin
                    if (accept) begin
                        cnt_lo <= rx_data_i;
                        state  <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (accept) begin
                        word_cnt <= n_in;
                        if (32'(n_in) > MAX_WORDS) begin
                            state      <= ERR;
                            busy_o     <= 1'b0;
                            load_err_o <= 1'b1;
                        end else if (n_in == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum     <= csum ^ rx_data_i;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= rx_data_i;
                            2'd1:    word_buf[15:8]  <= rx_data_i;
                            2'd2:    word_buf[23:16] <= rx_data_i;
                            default: begin
                                mem_we_o    <= 1'b1;
                                mem_addr_o  <= word_idx[ADDR_WIDTH-1:0];
                                mem_wdata_o <= {rx_data_i, word_buf};
                                word_idx    <= word_idx + 1'b1;
                                if (last_word)
                                    state <= CSUM;
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (accept) begin
                        busy_o <= 1'b0;
                        if (rx_data_i == csum) begin
                            state        <= DONE;
                            load_done_o  <= 1'b1;
                            core_rst_n_o <= 1'b1;
                        end else begin
                            state      <= ERR;
                            load_err_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A byte on the expiry edge wins: the timeout only fires on a silent edge.
            if (busy_o && !accept && tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                state      <= ERR;
                busy_o     <= 1'b0;
                load_err_o <= 1'b1;
            end
        end
    end

endmodule
